// File: rtl/sram_stream_loader.sv
// Byte-stream boot loader: packs bytes little-endian into NB_COL-byte words and
// writes them to a byte-write SRAM from BASE_ADDR. Optional readback check: LOADER_VERIFY_EN.
module sram_stream_loader #(
   parameter int unsigned NB_COL     = 4,
   parameter int unsigned COL_WIDTH  = 8,
   parameter int unsigned ADDR_WIDTH = 13,
   parameter int unsigned BASE_ADDR  = 0
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          start,
   input  logic [COL_WIDTH-1:0]          s_data,
   input  logic                          s_valid,
   input  logic                          s_last,
   output logic                          s_ready,
   output logic [ADDR_WIDTH-1:0]         sram_addr,
   output logic [NB_COL*COL_WIDTH-1:0]   sram_din,
   output logic [NB_COL-1:0]             sram_we,
   output logic                          sram_en,
   output logic                          busy,
   output logic                          done,
   output logic                          error,
   output logic [ADDR_WIDTH:0]           word_count,
   output logic [15:0]                   checksum
`ifdef LOADER_VERIFY_EN
   ,
   input  logic [NB_COL*COL_WIDTH-1:0]   sram_dout,
   output logic                          verify_ok,
   output logic                          verify_fail
`endif
);

   localparam int unsigned DW = NB_COL * COL_WIDTH;
   localparam int unsigned LW = (NB_COL > 1) ? $clog2(NB_COL) : 1;
   localparam int unsigned CW = ADDR_WIDTH + 1;
   localparam logic [ADDR_WIDTH-1:0] BASE     = ADDR_WIDTH'(BASE_ADDR);
   localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;

   typedef enum logic [2:0] {S_IDLE, S_RECV, S_WRITE, S_DONE, S_ERR, S_VERIFY} state_t;

   state_t                state;
   logic [DW-1:0]         pack, pack_nxt;
   logic [NB_COL-1:0]     fill, fill_nxt;
   logic [LW-1:0]         lane;
   logic [ADDR_WIDTH-1:0] waddr;
   logic                  last_seen;
   logic                  hs_c, word_end_c;

`ifdef LOADER_VERIFY_EN
   logic [NB_COL-1:0] last_mask;
   logic [CW-1:0]     rd_iss, rd_rsp;
   logic              rd_pend;
   logic [15:0]       vsum, rsp_sum_c, vsum_final_c;

   // Byte sum over the lanes that were actually written
   function automatic logic [15:0] lane_sum(input logic [DW-1:0] w, input logic [NB_COL-1:0] m);
      logic [15:0] s;
      s = '0;
      for (int i = 0; i < NB_COL; i++)
         if (m[i]) s = s + 16'(w[i*COL_WIDTH +: COL_WIDTH]);
      return s;
   endfunction

   always_comb begin
      rsp_sum_c    = lane_sum(sram_dout, (rd_rsp == word_count - CW'(1)) ? last_mask : '1);
      vsum_final_c = vsum + rsp_sum_c;
   end
`endif

   // Next pack/fill values for the byte being accepted this cycle
   always_comb begin
      hs_c       = s_valid && s_ready && (state == S_RECV);
      word_end_c = (lane == LW'(NB_COL - 1)) || s_last;
      pack_nxt   = pack;
      pack_nxt[32'(lane)*COL_WIDTH +: COL_WIDTH] = s_data;
      fill_nxt   = fill | (NB_COL'(1) << lane);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         pack       <= '0;
         fill       <= '0;
         lane       <= '0;
         waddr      <= '0;
         last_seen  <= 1'b0;
         s_ready    <= 1'b0;
         sram_addr  <= '0;
         sram_din   <= '0;
         sram_we    <= '0;
         sram_en    <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         error      <= 1'b0;
         word_count <= '0;
         checksum   <= '0;
`ifdef LOADER_VERIFY_EN
         last_mask   <= '0;
         rd_iss      <= '0;
         rd_rsp      <= '0;
         rd_pend     <= 1'b0;
         vsum        <= '0;
         verify_ok   <= 1'b0;
         verify_fail <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  word_count <= '0;
                  checksum   <= '0;
                  error      <= 1'b0;
                  pack       <= '0;
                  fill       <= '0;
                  lane       <= '0;
                  last_seen  <= 1'b0;
                  waddr      <= BASE;
                  busy       <= 1'b1;
                  s_ready    <= 1'b1;
                  state      <= S_RECV;
`ifdef LOADER_VERIFY_EN
                  verify_ok   <= 1'b0;
                  verify_fail <= 1'b0;
                  rd_pend     <= 1'b0;
`endif
               end
            end
            S_RECV: begin
               if (hs_c) begin
                  pack     <= pack_nxt;
                  fill     <= fill_nxt;
                  lane     <= lane + LW'(1);
                  checksum <= checksum + 16'(s_data);
                  if (s_last) last_seen <= 1'b1;
                  // Write strobe registered so it lands the cycle after the completing byte
                  if (word_end_c) begin
                     s_ready   <= 1'b0;
                     sram_en   <= 1'b1;
                     sram_we   <= fill_nxt;
                     sram_din  <= pack_nxt;
                     sram_addr <= waddr;
                     state     <= S_WRITE;
                  end
               end
            end
            S_WRITE: begin
               sram_en    <= 1'b0;
               sram_we    <= '0;
               word_count <= word_count + CW'(1);
               pack       <= '0;
               fill       <= '0;
               lane       <= '0;
               if (last_seen) begin
`ifdef LOADER_VERIFY_EN
                  last_mask <= fill;
                  sram_en   <= 1'b1;
                  sram_addr <= BASE;
                  rd_iss    <= CW'(1);
                  rd_rsp    <= '0;
                  rd_pend   <= 1'b0;
                  vsum      <= '0;
                  state     <= S_VERIFY;
`else
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= S_DONE;
`endif
               end else if (waddr == ADDR_MAX) begin
                  error <= 1'b1;
                  busy  <= 1'b0;
                  state <= S_ERR;
               end else begin
                  waddr   <= waddr + ADDR_WIDTH'(1);
                  s_ready <= 1'b1;
                  state   <= S_RECV;
               end
            end
`ifdef LOADER_VERIFY_EN
            S_VERIFY: begin
               // Reads are pipelined: one issued per cycle, data returns a cycle later
               rd_pend <= sram_en;
               if (rd_iss < word_count) begin
                  sram_addr <= sram_addr + ADDR_WIDTH'(1);
                  rd_iss    <= rd_iss + CW'(1);
               end else begin
                  sram_en <= 1'b0;
               end
               if (rd_pend) begin
                  vsum   <= vsum_final_c;
                  rd_rsp <= rd_rsp + CW'(1);
                  if (rd_rsp == word_count - CW'(1)) begin
                     verify_ok   <= (vsum_final_c == checksum);
                     verify_fail <= (vsum_final_c != checksum);
                     done        <= 1'b1;
                     busy        <= 1'b0;
                     state       <= S_DONE;
                  end
               end
            end
`endif
            S_DONE:  state <= S_IDLE;
            S_ERR:   state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sram_stream_loader.sv
// Directed bench for sram_stream_loader: default instance plus a 2-bit-address
// instance for the overflow path; SRAM behavioural model included.
module tb_sram_stream_loader;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, start, start2, s_valid, s_last;
   logic [7:0]  s_data;
   logic        s_ready, sram_en, busy, done, error;
   logic [12:0] sram_addr;
   logic [31:0] sram_din;
   logic [3:0]  sram_we;
   logic [13:0] word_count;
   logic [15:0] checksum;
   logic        s_ready2, sram_en2, busy2, done2, error2;
   logic [1:0]  sram_addr2;
   logic [31:0] sram_din2;
   logic [3:0]  sram_we2;
   logic [2:0]  word_count2;
   logic [15:0] checksum2;
`ifdef LOADER_VERIFY_EN
   logic [31:0] sram_dout, sram_dout2;
   logic        verify_ok, verify_fail, vok2, vfail2;
   assign sram_dout2 = '0;
`endif

   sram_stream_loader dut (
      .clk(clk), .rst_n(rst_n), .start(start), .s_data(s_data), .s_valid(s_valid),
      .s_last(s_last), .s_ready(s_ready), .sram_addr(sram_addr), .sram_din(sram_din),
      .sram_we(sram_we), .sram_en(sram_en), .busy(busy), .done(done), .error(error),
      .word_count(word_count), .checksum(checksum)
`ifdef LOADER_VERIFY_EN
      , .sram_dout(sram_dout), .verify_ok(verify_ok), .verify_fail(verify_fail)
`endif
   );

   sram_stream_loader #(.ADDR_WIDTH(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .start(start2), .s_data(s_data), .s_valid(s_valid),
      .s_last(s_last), .s_ready(s_ready2), .sram_addr(sram_addr2), .sram_din(sram_din2),
      .sram_we(sram_we2), .sram_en(sram_en2), .busy(busy2), .done(done2), .error(error2),
      .word_count(word_count2), .checksum(checksum2)
`ifdef LOADER_VERIFY_EN
      , .sram_dout(sram_dout2), .verify_ok(vok2), .verify_fail(vfail2)
`endif
   );

   // Byte-write SRAM model with one-cycle read latency and a corruption hook
   logic [31:0] mem [16];
   logic        corrupt = 1'b0;
   always @(posedge clk) begin
      if (sram_en) begin
         for (int i = 0; i < 4; i++)
            if (sram_we[i]) mem[sram_addr[3:0]][i*8 +: 8] <= sram_din[i*8 +: 8];
`ifdef LOADER_VERIFY_EN
         if (sram_we == 4'h0)
            sram_dout <= mem[sram_addr[3:0]] ^ ((corrupt && sram_addr == 13'd1) ? 32'h0000_0100 : 32'h0);
`endif
      end
   end

   int          cyc = 0, wr_n = 0, rd_n = 0, done_n = 0, done_cyc = 0, wr2_n = 0, done2_n = 0;
   logic [12:0] wr_addr [64];
   logic [31:0] wr_din  [64];
   logic [3:0]  wr_we   [64];
   logic        wr_rdy  [64];
   int          wr_cyc  [64];
   logic [12:0] rd_addr [64];
   logic [1:0]  wr2_addr[16];
   logic [31:0] wr2_din [16];
   logic        done_busy = 1'b1;

   always @(negedge clk) begin
      cyc <= cyc + 1;
      if (sram_en && sram_we != 4'h0 && wr_n < 64) begin
         wr_addr[wr_n] = sram_addr; wr_din[wr_n] = sram_din; wr_we[wr_n] = sram_we;
         wr_rdy[wr_n] = s_ready; wr_cyc[wr_n] = cyc; wr_n = wr_n + 1;
      end
      if (sram_en && sram_we == 4'h0 && rd_n < 64) begin
         rd_addr[rd_n] = sram_addr; rd_n = rd_n + 1;
      end
      if (done) begin done_n = done_n + 1; done_cyc = cyc; done_busy = busy; end
      if (sram_en2 && sram_we2 != 4'h0 && wr2_n < 16) begin
         wr2_addr[wr2_n] = sram_addr2; wr2_din[wr2_n] = sram_din2; wr2_n = wr2_n + 1;
      end
      if (done2) done2_n = done2_n + 1;
   end

   int checks = 0, fails = 0;

   task automatic pulse_start(input bit sel);
      @(negedge clk);
      if (sel) start2 = 1'b1; else start = 1'b1;
      @(negedge clk);
      start = 1'b0; start2 = 1'b0;
   endtask

   task automatic send(input logic [7:0] d, input bit last, input bit sel);
      int n = 0;
      s_valid = 1'b1; s_data = d; s_last = last;
      while (((sel ? s_ready2 : s_ready) !== 1'b1) && n < 40) begin
         @(negedge clk); n++;
      end
      if (n >= 40) begin
         checks++; fails++;
         $display("FAIL send_timeout byte=%h got no s_ready required s_ready=1", d);
      end
      @(negedge clk);
      s_valid = 1'b0; s_last = 1'b0;
   endtask

   task automatic wait_done(input int base);
      int n = 0;
      while (done_n == base && n < 60) begin @(negedge clk); n++; end
      if (n >= 60) begin
         checks++; fails++;
         $display("FAIL done_timeout got done_n=%0d required >%0d", done_n, base);
      end
      #1;
   endtask

   task automatic test_reset;
      rst_n = 1'b0; start = 1'b0; start2 = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = '0;
      repeat (2) @(negedge clk);
      checks++; if ({sram_en, sram_we, busy, done, error, s_ready} !== 10'b0) begin
         fails++; $display("FAIL reset_flags got=%b required=0", {sram_en, sram_we, busy, done, error, s_ready}); end
      checks++; if (sram_addr !== 13'h0 || sram_din !== 32'h0) begin
         fails++; $display("FAIL reset_bus got addr=%h din=%h required 0", sram_addr, sram_din); end
      checks++; if (word_count !== 14'h0 || checksum !== 16'h0) begin
         fails++; $display("FAIL reset_counts got wc=%h cs=%h required 0", word_count, checksum); end
      rst_n = 1'b1;
   endtask

   task automatic test_single_word;
      int b = wr_n, dn = done_n;
      logic [7:0] bytes [4];
      bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33; bytes[3] = 8'h44;
      pulse_start(0);
      for (int i = 0; i < 4; i++) send(bytes[i], i == 3, 0);
      wait_done(dn);
      checks++; if (wr_n - b !== 1) begin fails++; $display("FAIL single_count got=%0d required=1", wr_n - b); end
      checks++; if (wr_addr[b] !== 13'h0 || wr_we[b] !== 4'hF) begin
         fails++; $display("FAIL single_addr_we got addr=%h we=%b required 0/1111", wr_addr[b], wr_we[b]); end
      checks++; if (wr_din[b] !== 32'h44332211) begin fails++; $display("FAIL single_din got=%h required=44332211", wr_din[b]); end
`ifndef LOADER_VERIFY_EN
      checks++; if (done_cyc !== wr_cyc[b] + 1) begin
         fails++; $display("FAIL single_done_latency got=%0d required=%0d", done_cyc, wr_cyc[b] + 1); end
`endif
      checks++; if (done_busy !== 1'b0) begin fails++; $display("FAIL single_busy_at_done got=%b required=0", done_busy); end
      checks++; if (word_count !== 14'd1) begin fails++; $display("FAIL single_wc got=%0d required=1", word_count); end
      checks++; if (checksum !== 16'h00AA) begin fails++; $display("FAIL single_cs got=%h required=00aa", checksum); end
   endtask

   task automatic test_nine_bytes(input bit bad);
      int b = wr_n, dn = done_n, rb = rd_n;
      pulse_start(0);
      for (int i = 1; i <= 9; i++) send(8'(i), i == 9, 0);
      wait_done(dn);
      checks++; if (wr_n - b !== 3) begin fails++; $display("FAIL nine_count got=%0d required=3", wr_n - b); end
      checks++; if (wr_din[b] !== 32'h04030201 || wr_din[b+1] !== 32'h08070605) begin
         fails++; $display("FAIL nine_full_din got %h %h required 04030201 08070605", wr_din[b], wr_din[b+1]); end
      checks++; if (wr_din[b+2] !== 32'h00000009 || wr_we[b+2] !== 4'b0001 || wr_addr[b+2] !== 13'd2) begin
         fails++; $display("FAIL nine_partial got din=%h we=%b addr=%h required 00000009/0001/2",
                           wr_din[b+2], wr_we[b+2], wr_addr[b+2]); end
      checks++; if (word_count !== 14'd3 || checksum !== 16'h002D) begin
         fails++; $display("FAIL nine_counts got wc=%0d cs=%h required 3/002d", word_count, checksum); end
`ifdef LOADER_VERIFY_EN
      checks++; if (rd_n - rb !== 3 || rd_addr[rb] !== 13'd0 || rd_addr[rb+2] !== 13'd2) begin
         fails++; $display("FAIL nine_reads got n=%0d required 3 reads addr 0..2", rd_n - rb); end
      checks++; if ({verify_ok, verify_fail} !== (bad ? 2'b01 : 2'b10)) begin
         fails++; $display("FAIL nine_verify got ok/fail=%b required=%b", {verify_ok, verify_fail}, bad ? 2'b01 : 2'b10); end
`else
      checks++; if (rd_n - rb !== 0 || bad !== 1'b0) begin fails++; $display("FAIL nine_no_reads got=%0d required=0", rd_n - rb); end
`endif
   endtask

   task automatic test_gaps_restart;
      int b = wr_n, dn = done_n;
      pulse_start(0);
      for (int i = 0; i < 8; i++) begin
         send(8'hA0 + 8'(i), i == 7, 0);
         repeat ($urandom_range(0, 2)) @(negedge clk);
         if (i == 2) begin
            start = 1'b1; @(negedge clk); start = 1'b0;
         end
      end
      wait_done(dn);
      checks++; if (wr_n - b !== 2) begin fails++; $display("FAIL gaps_count got=%0d required=2", wr_n - b); end
      checks++; if (wr_din[b] !== 32'hA3A2A1A0 || wr_din[b+1] !== 32'hA7A6A5A4) begin
         fails++; $display("FAIL gaps_din got %h %h required a3a2a1a0 a7a6a5a4", wr_din[b], wr_din[b+1]); end
      checks++; if (wr_rdy[b] !== 1'b0 || wr_rdy[b+1] !== 1'b0) begin
         fails++; $display("FAIL gaps_ready_in_write got %b%b required 00", wr_rdy[b], wr_rdy[b+1]); end
      checks++; if (word_count !== 14'd2 || checksum !== 16'h051C || done_n - dn !== 1) begin
         fails++; $display("FAIL gaps_counts got wc=%0d cs=%h dones=%0d required 2/051c/1", word_count, checksum, done_n - dn); end
   endtask

   task automatic test_overflow;
      int b = wr2_n, dn = done2_n;
      logic saw_rdy = 1'b0;
      pulse_start(1);
      for (int i = 0; i < 16; i++) send(8'(i), 1'b0, 1);
      s_valid = 1'b1; s_data = 8'h10;
      repeat (6) begin @(negedge clk); saw_rdy |= s_ready2; end
      s_valid = 1'b0;
      checks++; if (wr2_n - b !== 4 || wr2_addr[b] !== 2'd0 || wr2_addr[b+3] !== 2'd3) begin
         fails++; $display("FAIL ovf_writes got n=%0d required 4 writes addr 0..3", wr2_n - b); end
      checks++; if (wr2_din[b+3] !== 32'h0F0E0D0C) begin fails++; $display("FAIL ovf_last_din got=%h required=0f0e0d0c", wr2_din[b+3]); end
      checks++; if (error2 !== 1'b1 || busy2 !== 1'b0 || done2_n !== dn || saw_rdy !== 1'b0) begin
         fails++; $display("FAIL ovf_error got err=%b busy=%b dones=%0d rdy=%b required 1/0/0/0",
                           error2, busy2, done2_n - dn, saw_rdy); end
      checks++; if (word_count2 !== 3'd4 || checksum2 !== 16'h0078) begin
         fails++; $display("FAIL ovf_counts got wc=%0d cs=%h required 4/0078", word_count2, checksum2); end
`ifdef LOADER_VERIFY_EN
      checks++; if ({vok2, vfail2} !== 2'b00) begin fails++; $display("FAIL ovf_verify got=%b required=00", {vok2, vfail2}); end
`endif
      pulse_start(1);
      #1;
      checks++; if (error2 !== 1'b0 || busy2 !== 1'b1) begin
         fails++; $display("FAIL ovf_restart got err=%b busy=%b required 0/1", error2, busy2); end
   endtask

   task automatic test_reset_mid_load;
      int b, dn;
      pulse_start(0);
      send(8'hAA, 1'b0, 0);
      send(8'hBB, 1'b0, 0);
      b = wr_n;
      rst_n = 1'b0;
      #1;
      checks++; if ({sram_en, busy, s_ready, error} !== 4'b0 || checksum !== 16'h0 || sram_din !== 32'h0) begin
         fails++; $display("FAIL rst_mid_outputs got flags=%b cs=%h din=%h required 0",
                           {sram_en, busy, s_ready, error}, checksum, sram_din); end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      checks++; if (wr_n !== b) begin fails++; $display("FAIL rst_mid_no_write got=%0d required=0", wr_n - b); end
      dn = done_n;
      pulse_start(0);
      send(8'h55, 1'b0, 0); send(8'h66, 1'b0, 0); send(8'h77, 1'b0, 0); send(8'h88, 1'b1, 0);
      wait_done(dn);
      checks++; if (wr_n - b !== 1 || wr_din[b] !== 32'h88776655 || wr_we[b] !== 4'hF || wr_addr[b] !== 13'h0) begin
         fails++; $display("FAIL rst_mid_reload got n=%0d din=%h required 1/88776655", wr_n - b, wr_din[b]); end
      checks++; if (word_count !== 14'd1 || checksum !== 16'h01BA) begin
         fails++; $display("FAIL rst_mid_counts got wc=%0d cs=%h required 1/01ba", word_count, checksum); end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single_word();
      test_nine_bytes(1'b0);
      test_gaps_restart();
      test_overflow();
      test_reset_mid_load();
`ifdef LOADER_VERIFY_EN
      corrupt = 1'b1;
      test_nine_bytes(1'b1);
      corrupt = 1'b0;
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule

// File: doc/sram_stream_loader.md
Name: sram_stream_loader

Overview:
- Initiator for the single-port byte-write SRAM port: drives address, write data, byte-write enables and enable.
- Accepts a byte stream from the loader front end (UART/SPI byte deserialiser) and packs bytes little-endian into NB_COL-byte words.
- Writes consecutive words from BASE_ADDR and keeps a running byte checksum for host-side confirmation.
- Sits between the byte receiver and the firmware SRAM during boot load.

Parameters:
- NB_COL, 4, bytes per SRAM word (byte-enable width)
- COL_WIDTH, 8, bits per byte lane
- ADDR_WIDTH, 13, SRAM address width
- BASE_ADDR, 0, first word address written

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  pulse; begins a load when idle
- s_data  in  COL_WIDTH  stream byte
- s_valid  in  1  byte valid
- s_last  in  1  marks final byte of image (qualified by s_valid)
- s_ready  out  1  loader accepts byte
- sram_addr  out  ADDR_WIDTH  word address
- sram_din  out  NB_COL*COL_WIDTH  write data
- sram_we  out  NB_COL  byte-write enables
- sram_en  out  1  SRAM enable
- busy  out  1  load in progress
- done  out  1  one-cycle completion pulse
- error  out  1  sticky overflow flag
- word_count  out  ADDR_WIDTH+1  words written in last load
- checksum  out  16  sum of accepted bytes mod 2^16

Behaviour:
- Reset: all outputs 0, state IDLE, lane index 0, pack register 0.
- States: IDLE, RECV, WRITE, DONE, ERR.
- IDLE:
  - s_ready=0.
  - start=1 clears word_count, checksum, error and the pack register; sets address to BASE_ADDR; busy=1 from the next cycle; goes to RECV.
- RECV:
  - s_ready=1; a handshake is s_valid&&s_ready.
  - Each handshake stores s_data in lane[lane index], sets that lane's fill bit, adds the byte to checksum (16-bit wrap), and increments lane index.
  - Word complete (lane index == NB_COL-1, or s_last) -> WRITE.
- WRITE (exactly one cycle):
  - sram_en=1, sram_we=fill mask, sram_din=packed word (unfilled lanes 0), sram_addr=current address, s_ready=0.
  - Write strobe appears in the cycle after the completing handshake.
  - Next: word_count+1, clear pack register and fill mask, lane index=0.
  - If s_last was seen -> DONE.
  - Else if address == 2^ADDR_WIDTH-1 -> ERR.
  - Else address+1 -> RECV.
- Outside WRITE (and verify reads): sram_en=0, sram_we=0. sram_addr and sram_din hold their last values.
- DONE: done=1 for one cycle, busy=0 in that same cycle, -> IDLE. word_count and checksum hold until the next start.
- ERR: error=1 (sticky), busy=0, s_ready=0; done is never asserted; -> IDLE the next cycle. error clears only on the next start or on reset.
- start while busy: ignored.
- s_last on the first byte: one partial write with sram_we=0001.
- s_last on lane NB_COL-1: normal full write.
- Asynchronous reset mid-load: everything returns to reset values immediately; a partially packed word is discarded and not written.

Optional Feature:
- Macro: LOADER_VERIFY_EN.
- With the macro:
  - Adds outputs verify_ok and verify_fail (1 bit each, reset 0).
  - After the final WRITE, the loader enters VERIFY instead of DONE.
  - In VERIFY it issues reads (sram_en=1, sram_we=0) for addresses BASE_ADDR..BASE_ADDR+word_count-1. SRAM data arrives one cycle after each read.
  - Read data enters the byte sum only for lanes that were written: all lanes for full words, the saved final fill mask for the last word.
  - After the last response, verify_ok=1 if the sum equals checksum, otherwise verify_fail=1; then DONE. Both flags clear on start.
  - If data is read back from the address written in the final WRITE, the completed write must be returned.
- Without the macro: no VERIFY state, no verify ports; DONE follows the final WRITE directly.

Test Plan:
- Reset, then start, then stream bytes 11,22,33,44 with s_last on 44 -> one write at addr 0, sram_we=1111, sram_din=44332211, done one cycle later, word_count=1, checksum=0x00AA.
- Stream 9 bytes 01..09 with s_last on 09 -> writes addr 0 (04030201, we=1111), addr 1 (08070605, we=1111), addr 2 (00000009, we=0001); word_count=3, checksum=0x002D.
- s_valid toggled randomly and start re-pulsed mid-load -> packing is unaffected by gaps, the re-pulse is ignored, s_ready=0 in every WRITE cycle.
- ADDR_WIDTH=2 with 17 bytes and no s_last -> 4 writes (addr 0..3), then error=1, done never asserted; a later start clears error.
- rst_n asserted after 2 bytes of a word -> no sram_en pulse, all outputs 0; a subsequent full load behaves normally.
- LOADER_VERIFY_EN with the 9-byte image -> 3 reads after the writes, verify_ok=1. Force one SRAM byte corrupt before the reads -> verify_fail=1.
